// File: rtl/mastermind_game_ctrl_pkg.sv
// Shared types and constants for the mastermind game controller slice.
// Holds the peg/colour geometry, the FSM state encoding and the secret LFSR step.
package mastermind_game_ctrl_pkg;

    localparam int unsigned NUM_PEGS    = 4;
    localparam int unsigned COLOUR_W    = 3;
    localparam int unsigned NUM_COLOURS = 1 << COLOUR_W;
    localparam int unsigned LFSR_W      = NUM_PEGS * COLOUR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GUESS   = 3'd1,
        ST_SCORE   = 3'd2,
        ST_HISTORY = 3'd3,
        ST_WIN     = 3'd4,
        ST_LOSE    = 3'd5
    } state_t;

    typedef logic [COLOUR_W-1:0] peg_t;
    typedef peg_t [NUM_PEGS-1:0] pegs_t;

    // Fibonacci step, taps 12,11,10,4 (bits 11,10,9,3).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
    endfunction

endpackage

// File: rtl/mastermind_game_ctrl_scorer.sv
// Registered exact/partial scorer for one guess against the secret.
// Result is valid one clock after guess/secret are presented.
module mastermind_scorer
    import mastermind_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  pegs_t      guess,
    input  pegs_t      secret,
    output logic [2:0] exact,
    output logic [2:0] partial
);

    logic [2:0] exact_c;
    logic [2:0] total_c;
    logic [2:0] cnt_g;
    logic [2:0] cnt_s;

    // total = sum over colours of min(count in guess, count in secret)
    always_comb begin
        exact_c = '0;
        total_c = '0;
        cnt_g   = '0;
        cnt_s   = '0;
        for (int unsigned i = 0; i < NUM_PEGS; i++) begin
            if (guess[i] == secret[i]) exact_c = exact_c + 3'd1;
        end
        for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
            cnt_g = '0;
            cnt_s = '0;
            for (int unsigned i = 0; i < NUM_PEGS; i++) begin
                if (guess[i] == peg_t'(c))  cnt_g = cnt_g + 3'd1;
                if (secret[i] == peg_t'(c)) cnt_s = cnt_s + 3'd1;
            end
            total_c = total_c + ((cnt_g < cnt_s) ? cnt_g : cnt_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exact   <= '0;
            partial <= '0;
        end else begin
            exact   <= exact_c;
            partial <= total_c - exact_c;
        end
    end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Game sequencer: secret generation, guess editing, turn counting and scoring,
// plus the strobes that drive the guess-history store.
module mastermind_game_ctrl
    import mastermind_game_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TURNS = 8,
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_select,
    input  logic                btn_mode,
    output logic [COLOUR_W-1:0] guess3,
    output logic [COLOUR_W-1:0] guess2,
    output logic [COLOUR_W-1:0] guess1,
    output logic [COLOUR_W-1:0] guess0,
    output logic [1:0]          cursor,
    output logic                hist_mode,
    output logic                hist_store,
    output logic                hist_clear,
    output logic                hist_up,
    output logic                hist_down,
    output logic [2:0]          exact_cnt,
    output logic [2:0]          partial_cnt,
    output logic [3:0]          turn,
    output logic [2:0]          state,
    output logic                game_won,
    output logic                game_lost
);

    localparam logic [3:0] TURN_LIMIT = 4'(NUM_TURNS);

    state_t            state_q, state_n, ret_q, ret_n;
    logic [LFSR_W-1:0] lfsr_q;
    pegs_t             secret_q, secret_n, guess_q, guess_n, snap_q, snap_n;
    logic [1:0]        cursor_q, cursor_n;
    logic [3:0]        turn_q, turn_n, turn_inc;
    logic [2:0]        exact_q, exact_n, partial_q, partial_n;
    logic              hmode_q, hmode_n, store_q, store_n, clear_q, clear_n;
    logic              up_q, up_n, down_q, down_n, won_q, won_n, lost_q, lost_n;
    logic              phase_q, phase_n;
    logic [2:0]        sc_exact, sc_partial;
    logic              act_sel, act_mode, act_up, act_down, act_left, act_right;

    // One action per cycle; a consumed-but-ignored action still drops the rest.
    assign act_sel   = btn_select;
    assign act_mode  = !btn_select && btn_mode;
    assign act_up    = !btn_select && !btn_mode && btn_up;
    assign act_down  = !btn_select && !btn_mode && !btn_up && btn_down;
    assign act_right = !btn_select && !btn_mode && !btn_up && !btn_down && btn_right;
    assign act_left  = !btn_select && !btn_mode && !btn_up && !btn_down && !btn_right && btn_left;

    assign turn_inc = turn_q + 4'd1;

    mastermind_scorer u_scorer (
        .clk     (clk),
        .reset   (reset),
        .guess   (snap_q),
        .secret  (secret_q),
        .exact   (sc_exact),
        .partial (sc_partial)
    );

    always_comb begin
        state_n   = state_q;
        ret_n     = ret_q;
        secret_n  = secret_q;
        guess_n   = guess_q;
        snap_n    = snap_q;
        cursor_n  = cursor_q;
        turn_n    = turn_q;
        exact_n   = exact_q;
        partial_n = partial_q;
        hmode_n   = hmode_q;
        won_n     = won_q;
        lost_n    = lost_q;
        phase_n   = phase_q;
        store_n   = 1'b0;
        clear_n   = 1'b0;
        up_n      = 1'b0;
        down_n    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (act_sel) begin
                    secret_n  = pegs_t'(lfsr_q);
                    guess_n   = '0;
                    cursor_n  = '0;
                    turn_n    = '0;
                    exact_n   = '0;
                    partial_n = '0;
                    clear_n   = 1'b1;
                    state_n   = ST_GUESS;
                end
            end
            ST_GUESS: begin
                if (act_sel) begin
                    store_n = 1'b1;
                    snap_n  = guess_q;
                    phase_n = 1'b0;
                    state_n = ST_SCORE;
                end else if (act_mode) begin
                    if (turn_q != '0) begin
                        ret_n   = ST_GUESS;
                        hmode_n = 1'b1;
                        state_n = ST_HISTORY;
                    end
                end else if (act_up) begin
                    guess_n[cursor_q] = guess_q[cursor_q] + 3'd1;
                end else if (act_down) begin
                    guess_n[cursor_q] = guess_q[cursor_q] - 3'd1;
                end else if (act_right) begin
                    cursor_n = cursor_q + 2'd1;
                end else if (act_left) begin
                    cursor_n = cursor_q - 2'd1;
                end
            end
            ST_SCORE: begin
                // First cycle lets the scorer register; second cycle consumes it.
                if (!phase_q) begin
                    phase_n = 1'b1;
                end else begin
                    exact_n   = sc_exact;
                    partial_n = sc_partial;
                    turn_n    = turn_inc;
                    if (sc_exact == 3'(NUM_PEGS)) begin
                        won_n   = 1'b1;
                        state_n = ST_WIN;
                    end else if (turn_inc == TURN_LIMIT) begin
                        lost_n  = 1'b1;
                        state_n = ST_LOSE;
                    end else begin
                        state_n = ST_GUESS;
                    end
                end
            end
            ST_HISTORY: begin
                if (act_mode) begin
                    hmode_n = 1'b0;
                    state_n = ret_q;
                end else if (act_up) begin
                    up_n = 1'b1;
                end else if (act_down) begin
                    down_n = 1'b1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (act_sel) begin
                    won_n   = 1'b0;
                    lost_n  = 1'b0;
                    state_n = ST_IDLE;
                end else if (act_mode) begin
                    ret_n   = state_q;
                    hmode_n = 1'b1;
                    state_n = ST_HISTORY;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_GUESS;
            lfsr_q    <= LFSR_SEED;
            secret_q  <= '0;
            guess_q   <= '0;
            snap_q    <= '0;
            cursor_q  <= '0;
            turn_q    <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            hmode_q   <= 1'b0;
            store_q   <= 1'b0;
            clear_q   <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            ret_q     <= ret_n;
            lfsr_q    <= lfsr_next(lfsr_q);
            secret_q  <= secret_n;
            guess_q   <= guess_n;
            snap_q    <= snap_n;
            cursor_q  <= cursor_n;
            turn_q    <= turn_n;
            exact_q   <= exact_n;
            partial_q <= partial_n;
            hmode_q   <= hmode_n;
            store_q   <= store_n;
            clear_q   <= clear_n;
            up_q      <= up_n;
            down_q    <= down_n;
            won_q     <= won_n;
            lost_q    <= lost_n;
            phase_q   <= phase_n;
        end
    end

    assign guess3      = guess_q[3];
    assign guess2      = guess_q[2];
    assign guess1      = guess_q[1];
    assign guess0      = guess_q[0];
    assign cursor      = cursor_q;
    assign hist_mode   = hmode_q;
    assign hist_store  = store_q;
    assign hist_clear  = clear_q;
    assign hist_up     = up_q;
    assign hist_down   = down_q;
    assign exact_cnt   = exact_q;
    assign partial_cnt = partial_q;
    assign turn        = turn_q;
    assign state       = state_q;
    assign game_won    = won_q;
    assign game_lost   = lost_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl: vector table for guess editing and
// button priority, hand sequences for scoring, history, win/lose and reset.
module tb_mastermind_game_ctrl;

    localparam logic [11:0] SEED = 12'h29C;  // secret {1,2,3,4} on an immediate start

    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_SEL  = 6'b100000;
    localparam logic [5:0] B_MODE = 6'b010000;
    localparam logic [5:0] B_UP   = 6'b001000;
    localparam logic [5:0] B_DN   = 6'b000100;
    localparam logic [5:0] B_LT   = 6'b000010;
    localparam logic [5:0] B_RT   = 6'b000001;

    localparam int S_IDLE = 0, S_GUESS = 1, S_SCORE = 2, S_HIST = 3, S_WIN = 4, S_LOSE = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
    logic btn_down = 1'b0, btn_select = 1'b0, btn_mode = 1'b0;
    logic [2:0] guess3, guess2, guess1, guess0;
    logic [1:0] cursor;
    logic       hist_mode, hist_store, hist_clear, hist_up, hist_down;
    logic [2:0] exact_cnt, partial_cnt, state;
    logic [3:0] turn;
    logic       game_won, game_lost;

    int errors = 0;
    int checks = 0;

    logic [2:0] mg [4];
    logic [1:0] mc;

    typedef struct {
        string      name;
        logic [5:0] btn;
        logic [11:0] g;
        logic [1:0] cur;
        int         st;
        logic       hm;
    } vec_t;

    vec_t vecs [12];

    mastermind_game_ctrl #(.NUM_TURNS(8), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_select(btn_select), .btn_mode(btn_mode),
        .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
        .cursor(cursor), .hist_mode(hist_mode), .hist_store(hist_store),
        .hist_clear(hist_clear), .hist_up(hist_up), .hist_down(hist_down),
        .exact_cnt(exact_cnt), .partial_cnt(partial_cnt), .turn(turn),
        .state(state), .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
    endfunction

    function automatic logic [11:0] model_guess();
        return {mg[3], mg[2], mg[1], mg[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cycle(input logic [5:0] b);
        {btn_select, btn_mode, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_select, btn_mode, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(B_NONE);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_guess"}, {guess3, guess2, guess1, guess0}, 0);
        chk({tag, "_cursor"}, cursor, 0);
        chk({tag, "_turn"}, turn, 0);
        chk({tag, "_scores"}, {exact_cnt, partial_cnt}, 0);
        chk({tag, "_strobes"}, {hist_store, hist_clear, hist_up, hist_down}, 0);
        chk({tag, "_flags"}, {hist_mode, game_won, game_lost}, 0);
    endtask

    // Reset, let the LFSR run until it holds target, then start a game.
    task automatic start_game(input logic [11:0] target);
        logic [11:0] s;
        int n;
        s = SEED;
        n = 0;
        while (s != target && n < 4096) begin
            s = lfsr_step(s);
            n++;
        end
        if (n >= 4096) begin
            errors++;
            checks++;
            $display("FAIL secret_reachable: got unreachable, expected 0x%0h", target);
            n = 0;
        end
        do_reset();
        repeat (n) cycle(B_NONE);
        cycle(B_SEL);
        chk("start_clear", hist_clear, 1);
        chk("start_state", state, S_GUESS);
        chk("start_guess", {guess3, guess2, guess1, guess0}, 0);
        chk("start_turn", turn, 0);
        chk("start_store", hist_store, 0);
        cycle(B_NONE);
        chk("clear_one_cycle", hist_clear, 0);
        for (int p = 0; p < 4; p++) mg[p] = 3'd0;
        mc = 2'd0;
    endtask

    task automatic set_guess(input logic [11:0] tgt);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4 && mc != 2'(p); k++) begin
                cycle(B_RT);
                mc = mc + 2'd1;
            end
            for (int k = 0; k < 8 && mg[p] != tgt[3*p +: 3]; k++) begin
                cycle(B_UP);
                mg[p] = mg[p] + 3'd1;
            end
        end
        chk("set_guess", {guess3, guess2, guess1, guess0}, tgt);
        chk("set_cursor", cursor, mc);
    endtask

    task automatic submit(input int ex, input int pa, input int tn, input int st);
        cycle(B_SEL);
        chk("submit_store", hist_store, 1);
        chk("submit_state", state, S_SCORE);
        cycle(B_UP);
        chk("score_store_low", hist_store, 0);
        chk("score_2nd_cycle", state, S_SCORE);
        cycle(B_NONE);
        chk("score_exit_state", state, st);
        chk("score_exact", exact_cnt, ex);
        chk("score_partial", partial_cnt, pa);
        chk("score_turn", turn, tn);
        chk("score_guess_kept", {guess3, guess2, guess1, guess0}, model_guess());
        chk("score_cursor_kept", cursor, mc);
    endtask

    initial begin
        vecs[0]  = '{"down_c0",     B_DN,        12'o0007, 2'd0, S_GUESS, 1'b0};
        vecs[1]  = '{"left_wrap",   B_LT,        12'o0007, 2'd3, S_GUESS, 1'b0};
        vecs[2]  = '{"up_c3_a",     B_UP,        12'o1007, 2'd3, S_GUESS, 1'b0};
        vecs[3]  = '{"up_c3_b",     B_UP,        12'o2007, 2'd3, S_GUESS, 1'b0};
        vecs[4]  = '{"up_left",     B_UP | B_LT, 12'o3007, 2'd3, S_GUESS, 1'b0};
        vecs[5]  = '{"right_wins",  B_RT | B_LT, 12'o3007, 2'd0, S_GUESS, 1'b0};
        vecs[6]  = '{"up_wins",     B_UP | B_DN, 12'o3000, 2'd0, S_GUESS, 1'b0};
        vecs[7]  = '{"mode_turn0",  B_MODE,      12'o3000, 2'd0, S_GUESS, 1'b0};
        vecs[8]  = '{"mode_drops",  B_MODE|B_UP, 12'o3000, 2'd0, S_GUESS, 1'b0};
        vecs[9]  = '{"left_again",  B_LT,        12'o3000, 2'd3, S_GUESS, 1'b0};
        vecs[10] = '{"down_c3",     B_DN,        12'o2000, 2'd3, S_GUESS, 1'b0};
        vecs[11] = '{"right_wrap",  B_RT,        12'o2000, 2'd0, S_GUESS, 1'b0};

        // Reset values and IDLE ignoring non-select buttons
        do_reset();
        chk_reset_outputs("reset");
        cycle(B_UP | B_RT | B_MODE);
        chk_reset_outputs("idle_ignore");

        // Game 1: secret {1,2,3,4}
        start_game(SEED);
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].btn);
            chk({vecs[i].name, "_guess"}, {guess3, guess2, guess1, guess0}, vecs[i].g);
            chk({vecs[i].name, "_cursor"}, cursor, vecs[i].cur);
            chk({vecs[i].name, "_state"}, state, vecs[i].st);
            chk({vecs[i].name, "_hmode"}, hist_mode, vecs[i].hm);
        end
        mg[3] = 3'd2; mg[2] = 3'd0; mg[1] = 3'd0; mg[0] = 3'd0;
        mc = 2'd0;

        set_guess(12'o4321);
        submit(0, 4, 1, S_GUESS);
        submit(0, 4, 2, S_GUESS);

        // History view at turn 2
        cycle(B_MODE);
        chk("hist_enter_state", state, S_HIST);
        chk("hist_enter_mode", hist_mode, 1);
        cycle(B_UP);
        chk("hist_up_pulse", {hist_up, hist_down}, 2'b10);
        cycle(B_NONE);
        chk("hist_up_single", {hist_up, hist_down}, 2'b00);
        cycle(B_UP | B_DN);
        chk("hist_up_wins", {hist_up, hist_down}, 2'b10);
        cycle(B_DN);
        chk("hist_down_pulse", {hist_up, hist_down}, 2'b01);
        cycle(B_LT);
        chk("hist_left_ign", cursor, mc);
        cycle(B_SEL);
        chk("hist_sel_ign", state, S_HIST);
        chk("hist_sel_nostore", hist_store, 0);
        cycle(B_MODE);
        chk("hist_exit_state", state, S_GUESS);
        chk("hist_exit_mode", hist_mode, 0);

        // Reset while scoring
        cycle(B_SEL);
        chk("pre_reset_score", state, S_SCORE);
        reset = 1'b1;
        cycle(B_NONE);
        reset = 1'b0;
        chk_reset_outputs("reset_in_score");

        // Game 2: secret {1,1,2,2}
        start_game(12'o1122);
        set_guess(12'o1213);
        submit(1, 2, 1, S_GUESS);
        set_guess(12'o1122);
        submit(4, 0, 2, S_WIN);
        chk("win_flags", {game_won, game_lost}, 2'b10);
        cycle(B_UP);
        chk("win_frozen", {guess3, guess2, guess1, guess0}, 12'o1122);
        chk("win_state", state, S_WIN);
        cycle(B_MODE);
        chk("win_hist_state", state, S_HIST);
        chk("win_hist_flags", {hist_mode, game_won}, 2'b11);
        cycle(B_MODE);
        chk("win_return", state, S_WIN);
        chk("win_return_mode", hist_mode, 0);
        cycle(B_SEL);
        chk("win_to_idle", state, S_IDLE);
        chk("win_cleared", {game_won, game_lost}, 2'b00);

        // Game 3: eight misses
        start_game(SEED);
        for (int t = 1; t <= 8; t++) submit(0, 0, t, (t == 8) ? S_LOSE : S_GUESS);
        chk("lose_flags", {game_won, game_lost}, 2'b01);
        cycle(B_UP);
        chk("lose_frozen", {guess3, guess2, guess1, guess0}, 0);
        chk("lose_state", state, S_LOSE);
        cycle(B_SEL);
        chk("lose_to_idle", state, S_IDLE);
        chk("lose_cleared", {game_won, game_lost}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
